// File: rtl/sample_frame_packer.sv
// sample_frame_packer
//   Snapshots the per-tick processing results into sequence-numbered frames.
//   Frames sit in a small multi-frame buffer and stream out one 32-bit word
//   per valid/ready handshake toward the PS-side DMA/FIFO.
//
//   Frame layout (L = NUM_WORDS+1 words):
//     word 0        : {SYNC, seq[15:0]}
//     words 1..L-1  : data_i words 0..NUM_WORDS-1
//
// Ports
//   clk_i, reset_i     : clock, synchronous active-high reset
//   tick_i             : one-cycle sample strobe
//   data_i             : payload, word k = data_i[32k+31:32k]
//   decim_i            : keep 1 of every decim_i ticks (0 behaves as 1)
//   m_data_o/m_valid_o/m_ready_i/m_last_o : output word stream
//   dropped_o          : saturating count of discarded frames
//   frames_o           : committed frames currently buffered
module sample_frame_packer #(
  parameter int          NUM_WORDS   = 25,
  parameter int          FIFO_FRAMES = 4,
  parameter logic [15:0] SYNC        = 16'hA55A
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           tick_i,
  input  logic [NUM_WORDS*32-1:0]        data_i,
  input  logic [15:0]                    decim_i,
  output logic [31:0]                    m_data_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic                           m_last_o,
  output logic [15:0]                    dropped_o,
  output logic [$clog2(FIFO_FRAMES):0]   frames_o
);

  localparam int L  = NUM_WORDS + 1;
  localparam int IW = $clog2(L);
  localparam int PW = $clog2(FIFO_FRAMES);
  localparam int FW = PW + 1;

  typedef enum logic {IDLE, WRITE} wstate_e;

  wstate_e           state_q, state_d;
  logic [15:0]       decCnt_q;
  logic [15:0]       seq_q;
  logic [15:0]       dropped_q;
  logic [L*32-1:0]   snap_q;
  logic [IW-1:0]     wIdx_q;
  logic [PW-1:0]     wrPtr_q;
  logic [FW-1:0]     frames_q;

  logic [IW-1:0]     rIdx_q;
  logic [PW-1:0]     issPtr_q;
  logic [FW-1:0]     inflight_q;
  logic [31:0]       ramData_q;
  logic              ramVld_q, ramLast_q;
  logic [31:0]       outData_q;
  logic              outVld_q, outLast_q;

  logic [31:0]       mem [FIFO_FRAMES][L];

  logic [15:0] decEff;
  logic eligible, accept, drop, commit;
  logic release_, outFree, pending, issue, issueLast, moveOut;

  assign decEff   = (decim_i == 16'd0) ? 16'd1 : decim_i;
  assign eligible = tick_i && (decCnt_q == 16'd0);
  assign accept   = eligible && (state_q == IDLE) && (frames_q != FW'(FIFO_FRAMES));
  assign drop     = eligible && !accept;
  assign commit   = (state_q == WRITE) && (wIdx_q == IW'(L-1));

  // Frames fully issued to the read pipeline but not yet handed off are
  // tracked separately, so the next frame can be fetched before the last word
  // of the current one is accepted and frames stream without gaps.
  assign outFree   = !outVld_q || m_ready_i;
  assign release_  = outVld_q && m_ready_i && outLast_q;
  assign pending   = frames_q > inflight_q;
  assign issue     = pending && (!ramVld_q || outFree);
  assign issueLast = issue && (rIdx_q == IW'(L-1));
  assign moveOut   = ramVld_q && outFree;

  // Writer next state: capture on an accepted tick, drain the snapshot into
  // the frame slot one word per cycle, then return to IDLE on commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WRITE;
      WRITE:   if (commit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decimation counter wraps with >= so a lowered decim_i takes effect at once.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      decCnt_q <= 16'd0;
    end else if (tick_i) begin
      decCnt_q <= (decCnt_q >= decEff - 16'd1) ? 16'd0 : decCnt_q + 16'd1;
    end
  end

  // Writer state, snapshot, sequence number, slot pointer and drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      seq_q     <= 16'd0;
      dropped_q <= 16'd0;
      snap_q    <= '0;
      wIdx_q    <= '0;
      wrPtr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        snap_q <= {data_i, SYNC, seq_q};
        wIdx_q <= '0;
      end else if (state_q == WRITE) begin
        wIdx_q <= wIdx_q + IW'(1);
      end
      if (commit) begin
        seq_q   <= seq_q + 16'd1;
        wrPtr_q <= wrPtr_q + PW'(1);
      end
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  // Frame RAM: one write port for the writer, one registered read port.
  always_ff @(posedge clk_i) begin
    if (state_q == WRITE) mem[wrPtr_q][wIdx_q] <= snap_q[wIdx_q*32 +: 32];
    if (issue) ramData_q <= mem[issPtr_q][rIdx_q];
  end

  // Frame occupancy bookkeeping shared between writer and reader.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frames_q   <= '0;
      inflight_q <= '0;
    end else begin
      frames_q   <= frames_q + (commit ? FW'(1) : FW'(0)) - (release_ ? FW'(1) : FW'(0));
      inflight_q <= inflight_q + (issueLast ? FW'(1) : FW'(0)) - (release_ ? FW'(1) : FW'(0));
    end
  end

  // Read pipeline: address issue, RAM data stage, and output register that
  // holds steady while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rIdx_q    <= '0;
      issPtr_q  <= '0;
      ramVld_q  <= 1'b0;
      ramLast_q <= 1'b0;
      outData_q <= 32'd0;
      outVld_q  <= 1'b0;
      outLast_q <= 1'b0;
    end else begin
      if (issue) begin
        rIdx_q    <= issueLast ? '0 : rIdx_q + IW'(1);
        ramLast_q <= issueLast;
        if (issueLast) issPtr_q <= issPtr_q + PW'(1);
      end
      if (issue) ramVld_q <= 1'b1;
      else if (moveOut) ramVld_q <= 1'b0;
      if (moveOut) begin
        outData_q <= ramData_q;
        outVld_q  <= 1'b1;
        outLast_q <= ramLast_q;
      end else if (outVld_q && m_ready_i) begin
        outVld_q  <= 1'b0;
        outLast_q <= 1'b0;
      end
    end
  end

  assign m_data_o  = outData_q;
  assign m_valid_o = outVld_q;
  assign m_last_o  = outLast_q;
  assign dropped_o = dropped_q;
  assign frames_o  = frames_q;

endmodule

// File: tb/tb_sample_frame_packer.sv
// Self-checking bench for sample_frame_packer: directed ticks push expected
// frames into a scoreboard queue; a monitor pops and compares each word the
// DUT hands off, and also checks the output holds while stalled.
module tb_sample_frame_packer;

  localparam int NW = 25;
  localparam int FF = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic [NW*32-1:0]  data;
  logic [15:0]       decim;
  logic              ready;
  logic [31:0]       mData;
  logic              mValid, mLast;
  logic [15:0]       dropped;
  logic [2:0]        frames;

  sample_frame_packer #(.NUM_WORDS(NW), .FIFO_FRAMES(FF), .SYNC(16'hA55A)) dut (
    .clk_i(clk), .reset_i(reset), .tick_i(tick), .data_i(data), .decim_i(decim),
    .m_data_o(mData), .m_valid_o(mValid), .m_ready_i(ready), .m_last_o(mLast),
    .dropped_o(dropped), .frames_o(frames)
  );

  always #5 clk = ~clk;

  logic [32:0] expQ [$];
  int          passCnt = 0;
  int          totalCnt = 0;
  logic [15:0] expSeq = 16'd0;
  bit          randReady = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected frame for one accepted tick: header then payload words base+k.
  task automatic pushFrame(input logic [31:0] base);
    expQ.push_back({1'b0, 16'hA55A, expSeq});
    for (int k = 0; k < NW; k++) expQ.push_back({(k == NW-1), base + 32'(k)});
    expSeq++;
  endtask

  task automatic applyStimulus(input logic [31:0] base, input bit expectAccept);
    for (int k = 0; k < NW; k++) data[32*k +: 32] = base + 32'(k);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    if (expectAccept) pushFrame(base);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    expQ.delete();
    expSeq = 16'd0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drainAll();
    int n = 0;
    while ((expQ.size() != 0 || mValid || frames != 3'd0) && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("drainTimeout", 32'(n < 2000), 32'd1);
    checkOutput("framesAfterDrain", 32'(frames), 32'd0);
  endtask

  // Monitor: compare every handed-off word against the scoreboard and
  // verify data/last stay put across a stalled cycle.
  logic        prevStall = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;
  always @(negedge clk) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", 32'(mValid), 32'd1);
        checkOutput("stallData", mData, prevData);
        checkOutput("stallLast", 32'(mLast), 32'(prevLast));
      end
      if (mValid && ready) begin
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("[TB] FAIL unexpectedWord: got %h expected none", mData);
        end else begin
          logic [32:0] e;
          e = expQ.pop_front();
          checkOutput("wordData", mData, e[31:0]);
          checkOutput("wordLast", 32'(mLast), 32'(e[32]));
        end
      end
      prevStall = mValid && !ready;
      prevData  = mData;
      prevLast  = mLast;
    end
  end

  always @(posedge clk) begin
    if (randReady) #1 ready = 1'($urandom_range(0, 1));
  end

  initial begin
    int n;
    reset = 1'b1; tick = 1'b0; data = '0; decim = 16'd0; ready = 1'b0;
    waitCycles(3);
    checkOutput("resetValid", 32'(mValid), 32'd0);
    checkOutput("resetLast", 32'(mLast), 32'd0);
    checkOutput("resetData", mData, 32'd0);
    checkOutput("resetFrames", 32'(frames), 32'd0);
    checkOutput("resetDropped", 32'(dropped), 32'd0);
    reset = 1'b0;
    expQ.delete();
    waitCycles(2);

    // Single frame latency and content.
    $display("[TB] single frame");
    ready = 1'b1;
    applyStimulus(32'h1000_0000, 1'b1);
    n = 0;
    while (!mValid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    checkOutput("tickToValid", 32'(n), 32'd28);
    drainAll();

    // Backpressure: buffer fills, extra frames dropped.
    $display("[TB] backpressure");
    doReset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'h2000_0000 + 32'(i) * 32'h100, i < 4);
      waitCycles(99);
    end
    checkOutput("fullFrames", 32'(frames), 32'd4);
    checkOutput("fullDropped", 32'(dropped), 32'd2);
    ready = 1'b1;
    drainAll();

    // Decimation by 3, then decim_i = 0.
    $display("[TB] decimation");
    doReset();
    decim = 16'd3;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(32'h4000_0000 + 32'(i) * 32'h100, (i % 3) == 0);
      waitCycles(39);
    end
    checkOutput("decimDropped", 32'(dropped), 32'd0);
    checkOutput("decimSeq", 32'(expSeq), 32'd3);
    decim = 16'd0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h5000_0000 + 32'(i) * 32'h100, 1'b1);
      waitCycles(39);
    end
    drainAll();

    // Tick while writer busy.
    $display("[TB] busy drop");
    doReset();
    applyStimulus(32'h6000_0000, 1'b1);
    waitCycles(9);
    applyStimulus(32'h6100_0000, 1'b0);
    checkOutput("busyDropped", 32'(dropped), 32'd1);
    waitCycles(60);
    applyStimulus(32'h6200_0000, 1'b1);
    drainAll();
    checkOutput("busyDroppedAfter", 32'(dropped), 32'd1);

    // Random backpressure mid-frame.
    $display("[TB] random ready");
    doReset();
    randReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h7000_0000 + 32'(i) * 32'h100, 1'b1);
      waitCycles(59);
    end
    randReady = 1'b0;
    waitCycles(1);
    ready = 1'b1;
    drainAll();

    // Reset in the middle of a streaming frame.
    $display("[TB] mid-stream reset");
    applyStimulus(32'h8000_0000, 1'b1);
    waitCycles(4);
    applyStimulus(32'h8100_0000, 1'b0);
    waitCycles(30);
    checkOutput("preResetDropped", 32'(dropped), 32'd1);
    reset = 1'b1;
    expQ.delete();
    waitCycles(1);
    checkOutput("midResetValid", 32'(mValid), 32'd0);
    checkOutput("midResetFrames", 32'(frames), 32'd0);
    checkOutput("midResetDropped", 32'(dropped), 32'd0);
    reset = 1'b0;
    expSeq = 16'd0;
    waitCycles(2);
    applyStimulus(32'h9000_0000, 1'b1);
    drainAll();

    // Drop counter saturation.
    $display("[TB] saturation");
    doReset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'hB000_0000 + 32'(i) * 32'h100, 1'b1);
      waitCycles(29);
    end
    checkOutput("satFrames", 32'(frames), 32'd4);
    tick = 1'b1;
    repeat (65534) @(posedge clk);
    #1 tick = 1'b0;
    checkOutput("satNearMax", 32'(dropped), 32'h0000_FFFE);
    tick = 1'b1;
    repeat (10) @(posedge clk);
    #1 tick = 1'b0;
    checkOutput("satMax", 32'(dropped), 32'h0000_FFFF);
    ready = 1'b1;
    drainAll();
    checkOutput("satHeld", 32'(dropped), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
